// File: rtl/seg_pkg.sv
// seg_pkg: shared scan state encoding, segment patterns and default scan rate for seg_scan.
// Contents: SCAN_DIV_DEF (default clk cycles per slot), state_t (scan FSM states),
//           BLANK and SEG_0..SEG_9 (active-low {g,f,e,d,c,b,a} patterns).
package seg_pkg;
    localparam int SCAN_DIV_DEF = 50;
    typedef enum logic [1:0] {GAP0, ONES, GAP1, TENS} state_t;
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: combinational BCD digit to active-low 7-segment decoder.
// Ports: digit [3:0] in  -- digit 0..9, anything above 9 decodes to BLANK
//        seg   [6:0] out -- {g,f,e,d,c,b,a}, active-low
module seg7_dec
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = BLANK;
        endcase
    end
endmodule

// File: rtl/seg_scan.sv
// seg_scan: two-digit multiplexed 7-segment scanner for a 0..15 count value.
// Ports: clk          in  -- system clock
//        rst          in  -- asynchronous active-low reset
//        en           in  -- display enable; low freezes scanning and blanks the display
//        in     [3:0] in  -- count value from the upstream counter stage
//        seg    [6:0] out -- segments {g,f,e,d,c,b,a}, active-low
//        an     [1:0] out -- anodes, active-low; an[0] ones digit, an[1] tens digit
//        dp           out -- decimal point, always off (1)
//        changed      out -- one-cycle pulse when a newly latched value differs from the last
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       dp,
    output logic       changed
);
    localparam logic [9:0] LAST = 10'(SCAN_DIV - 1);

    logic [3:0] sync1, sync2, val, val_nxt, ones, digit;
    logic [9:0] scan_cnt;
    logic       tick, load, tens;
    logic [6:0] dec_seg, seg_nxt;
    logic [1:0] an_nxt;
    state_t     state, state_nxt;

    assign dp   = 1'b1;
    assign tick = en && scan_cnt == LAST;
    // A new value is only taken on ONES entry, so a frame never mixes two values.
    assign load = tick && state == GAP0;

    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                GAP0: state_nxt = ONES;
                ONES: state_nxt = GAP1;
                GAP1: state_nxt = TENS;
                TENS: state_nxt = GAP0;
            endcase
        end
    end

    // Outputs are registered from the next state and next value so they change
    // on the same edge as the state transition.
    assign val_nxt = load ? sync2 : val;
    assign tens    = val_nxt >= 4'd10;
    assign ones    = val_nxt - (tens ? 4'd10 : 4'd0);
    assign digit   = state_nxt == ONES ? ones : {3'b000, tens};

    seg7_dec u_dec (
        .digit(digit),
        .seg  (dec_seg)
    );

    always_comb begin
        an_nxt  = 2'b11;
        seg_nxt = BLANK;
        if (en && state_nxt == ONES) begin
            an_nxt  = 2'b10;
            seg_nxt = dec_seg;
        end else if (en && state_nxt == TENS && tens) begin
            an_nxt  = 2'b01;
            seg_nxt = dec_seg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            val      <= '0;
            scan_cnt <= '0;
            state    <= GAP0;
            seg      <= BLANK;
            an       <= 2'b11;
            changed  <= 1'b0;
        end else begin
            sync1    <= in;
            sync2    <= sync1;
            if (en)
                scan_cnt <= scan_cnt == LAST ? '0 : scan_cnt + 10'd1;
            state    <= state_nxt;
            val      <= val_nxt;
            changed  <= load && sync2 != val;
            seg      <= seg_nxt;
            an       <= an_nxt;
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: self-checking bench for seg_scan with SCAN_DIV=4.
module tb_seg_scan;
    typedef struct {
        logic [3:0] val;
        logic [6:0] ones;
        logic [6:0] tens;
        logic [1:0] tens_an;
    } vec_t;

    typedef struct {
        logic [6:0] ones;
        logic [6:0] tens;
        logic [1:0] tens_an;
        logic       chg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] din = 4'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       dp;
    logic       changed;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t tbl[10];

    seg_scan #(.SCAN_DIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .in     (din),
        .seg    (seg),
        .an     (an),
        .dp     (dp),
        .changed(changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%b want=%b (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ones(output bit ok);
        logic [1:0] prev;
        prev = an;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (an == 2'b10 && prev != 2'b10) ok = 1'b1;
            prev = an;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_ones: no ONES entry within 40 cycles (t=%0t)", $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t       e;
        bit         ok;
        logic [3:0] last;
        logic [6:0] prev_tens;
        logic [1:0] prev_an;

        tbl = '{
            '{4'd12, 7'b0100100, 7'b1111001, 2'b01},
            '{4'd13, 7'b0110000, 7'b1111001, 2'b01},
            '{4'd15, 7'b0010010, 7'b1111001, 2'b01},
            '{4'd15, 7'b0010010, 7'b1111001, 2'b01},
            '{4'd0,  7'b1000000, 7'h7F,      2'b11},
            '{4'd9,  7'b0010000, 7'h7F,      2'b11},
            '{4'd10, 7'b1000000, 7'b1111001, 2'b01},
            '{4'd4,  7'b0011001, 7'h7F,      2'b11},
            '{4'd8,  7'b0000000, 7'h7F,      2'b11},
            '{4'd6,  7'b0000010, 7'h7F,      2'b11}
        };

        // Reset takes effect without any clock edge.
        #1 rst = 1'b0;
        #1;
        chk("rst_an", 7'(an), 7'(2'b11));
        chk("rst_seg", seg, 7'h7F);
        chk("rst_changed", 7'(changed), 7'(1'b0));
        chk("rst_dp", 7'(dp), 7'(1'b1));

        // in=7 at reset release: ONES on the fourth edge, GAP1 four later, TENS blank.
        din = 4'd7;
        en  = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        tick_n(3);
        chk("first_gap0_an", 7'(an), 7'(2'b11));
        tick_n(1);
        chk("first_ones_an", 7'(an), 7'(2'b10));
        chk("first_ones_seg", seg, 7'b1111000);
        chk("first_ones_changed", 7'(changed), 7'(1'b1));
        tick_n(1);
        chk("first_changed_drop", 7'(changed), 7'(1'b0));
        tick_n(3);
        chk("first_gap1_an", 7'(an), 7'(2'b11));
        tick_n(4);
        chk("first_tens_an", 7'(an), 7'(2'b11));
        chk("first_tens_seg", seg, 7'h7F);
        last      = 4'd7;
        prev_tens = 7'h7F;
        prev_an   = 2'b11;

        // Table: new value driven at each TENS entry, checked at the next ONES and TENS.
        for (int i = 0; i < 10; i++) begin
            din = tbl[i].val;
            sb.push_back('{tbl[i].ones, tbl[i].tens, tbl[i].tens_an, tbl[i].val != last});
            last = tbl[i].val;
            tick_n(3);
            chk("tens_hold_an", 7'(an), 7'(prev_an));
            chk("tens_hold_seg", seg, prev_tens);
            wait_ones(ok);
            e = sb.pop_front();
            if (ok) begin
                chk("ones_an", 7'(an), 7'(2'b10));
                chk("ones_seg", seg, e.ones);
                chk("ones_changed", 7'(changed), 7'(e.chg));
                tick_n(1);
                chk("changed_pulse_end", 7'(changed), 7'(1'b0));
                tick_n(7);
                chk("tens_an", 7'(an), 7'(e.tens_an));
                chk("tens_seg", seg, e.tens);
                prev_tens = e.tens;
                prev_an   = e.tens_an;
            end
        end

        // en low for 10 cycles during ONES: blanked and frozen, then resumes.
        din = 4'd9;
        wait_ones(ok);
        tick_n(1);
        en = 1'b0;
        tick_n(1);
        chk("en_off_an", 7'(an), 7'(2'b11));
        chk("en_off_seg", seg, 7'h7F);
        tick_n(9);
        chk("en_off_hold_an", 7'(an), 7'(2'b11));
        chk("en_off_hold_seg", seg, 7'h7F);
        chk("en_off_changed", 7'(changed), 7'(1'b0));
        en = 1'b1;
        tick_n(1);
        chk("en_on_an", 7'(an), 7'(2'b10));
        chk("en_on_seg", seg, 7'b0010000);
        tick_n(1);
        chk("en_on_still_ones", 7'(an), 7'(2'b10));
        tick_n(1);
        chk("en_on_gap1", 7'(an), 7'(2'b11));

        // Reset asserted mid-TENS with in=13 blanks immediately.
        din = 4'd13;
        wait_ones(ok);
        tick_n(8);
        chk("pre_rst_tens_an", 7'(an), 7'(2'b01));
        chk("pre_rst_tens_seg", seg, 7'b1111001);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_an", 7'(an), 7'(2'b11));
        chk("mid_rst_seg", seg, 7'h7F);
        chk("mid_rst_changed", 7'(changed), 7'(1'b0));
        #10 rst = 1'b1;
        tick_n(3);
        chk("post_rst_gap0_an", 7'(an), 7'(2'b11));
        tick_n(1);
        chk("post_rst_ones_an", 7'(an), 7'(2'b10));
        chk("post_rst_ones_seg", seg, 7'b0110000);
        chk("post_rst_changed", 7'(changed), 7'(1'b1));
        tick_n(8);
        chk("post_rst_tens_an", 7'(an), 7'(2'b01));
        chk("post_rst_tens_seg", seg, 7'b1111001);
        chk("end_dp", 7'(dp), 7'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50: clk cycles per display slot; legal range 2..1023.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low; the block resets immediately on negedge rst, independent of clk.
REQ-004 en  input  1  display enable; when low, scanning freezes and the display is blanked.
REQ-005 in  input  4  unsigned count value 0..15 from the upstream counter stage.
REQ-006 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-007 an  output  2  digit anodes, active-low; an[0] is the ones digit, an[1] is the tens digit.
REQ-008 dp  output  1  decimal point, active-low; held at 1 (off) at all times.
REQ-009 changed  output  1  one-cycle pulse when a newly latched value differs from the previously latched value.

Function
REQ-010 in passes through a two-flop synchroniser (sync2) before any other use.
REQ-011 Scan divider scan_cnt counts 0..SCAN_DIV-1 and wraps to 0; tick is asserted in the cycle where scan_cnt==SCAN_DIV-1 and en==1.
REQ-012 FSM states are GAP0, ONES, GAP1 and TENS, advancing in that order on each tick: GAP0->ONES->GAP1->TENS->GAP0.
REQ-013 On the GAP0->ONES edge: val <= sync2, and changed <= (sync2 != val); changed is 0 on every other edge.
REQ-014 BCD split of val: tens = (val>=10) ? 1 : 0; ones = val - 10*tens; the result is 4 bits wide with no overflow for inputs 0..15.
REQ-015 seg and an are registered and update on the same edge as the state transition, decoded from the next state.
REQ-016 ONES: an=2'b10, seg=dec(ones). TENS: an=2'b01, seg=dec(1) when tens==1; when tens==0 the digit is blanked with an=2'b11, seg=7'h7F. GAP0/GAP1: an=2'b11, seg=7'h7F.
REQ-017 dec(): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 Changes on in during ONES, GAP1 or TENS do not alter the display until the next ONES entry, so a frame never tears.
REQ-019 en==0: scan_cnt and state hold their values; an=2'b11 and seg=7'h7F from the next edge; changed=0. When en returns to 1, the held state's outputs reappear on the next edge and counting resumes from the held scan_cnt.
REQ-020 in must be stable for at least 2 clk cycles before the ONES entry for its value to be latched on that entry.

Reset
REQ-021 With rst low: scan_cnt=0, state=GAP0, val=0, sync2=0, seg=7'h7F, an=2'b11, dp=1, changed=0.
REQ-022 Reset asserted mid-frame blanks the display immediately; the first tick after reset release enters ONES.

Structure
REQ-023 Shared package seg_pkg holds the state encoding, the BLANK (7'h7F) and digit segment constants, and the default SCAN_DIV.
REQ-024 One sub-module, seg7_dec: combinational 4-bit digit in, 7-bit active-low segments out; inputs above 9 return BLANK.

Verification (SCAN_DIV=4)
REQ-025 Assert rst low mid-TENS with in=13 -> an=11, seg=7F, changed=0 with no clk edge required.
REQ-026 in=7, en=1, release reset -> first edge where scan_cnt==3 gives an=10, seg=1111000; GAP1 4 cycles later gives an=11; TENS is blanked (an=11).
REQ-027 in=13 -> ONES shows seg=0110000 with an=10; TENS shows seg=1111001 with an=01.
REQ-028 Shown value 7, change in to 12 during TENS -> display keeps 7 through GAP0; at the next ONES entry seg=0100100 and changed=1 for exactly 1 cycle.
REQ-029 en low for 10 cycles during ONES -> an=11, seg=7F, state held; en high -> ONES outputs restored, tick arrives after the remaining scan_cnt cycles.
REQ-030 in=15 held across two frames -> ONES=0010010, TENS=1111001; changed=1 on the first ONES entry only, 0 on the second.
